// File: rtl/ram_arb_pkg.sv
// Shared types and RAM geometry for the two-master RAM arbiter.
package ram_arb_pkg;

   localparam int RAM_DW = 16;
   localparam int RAM_AW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select: round-robin on ties, burst cap while the other waits.
module arb_rr_pick
   import ram_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BW        = $clog2(MAX_BURST + 1)
) (
   input  arb_state_t      i_st,
   input  logic [BW-1:0]   i_burst_cnt,
   input  logic            i_last,
   input  logic            i_req0,
   input  logic            i_req1,
   output logic            o_valid,
   output logic            o_idx
);

   localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

   logic w_cap;
   assign w_cap = (i_burst_cnt >= MAXB);

   // The owner keeps the grant until it has used its burst and the other side is waiting.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 1'b0;
      unique case (i_st)
         OWN0: begin
            if (i_req0 && (!w_cap || !i_req1)) begin
               o_valid = 1'b1;
               o_idx   = 1'b0;
            end else if (i_req1) begin
               o_valid = 1'b1;
               o_idx   = 1'b1;
            end
         end
         OWN1: begin
            if (i_req1 && (!w_cap || !i_req0)) begin
               o_valid = 1'b1;
               o_idx   = 1'b1;
            end else if (i_req0) begin
               o_valid = 1'b1;
               o_idx   = 1'b0;
            end
         end
         default: begin
            o_valid = i_req0 | i_req1;
            o_idx   = (i_req0 && i_req1) ? ~i_last : i_req1;
         end
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between m0 (CPU) and m1 (loader/debug).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DW        = RAM_DW,
   parameter int AW        = RAM_AW,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_w_en,
   input  logic [DW-1:0] m0_w_data,
   output logic          m0_gnt,
   output logic          m0_r_valid,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_w_en,
   input  logic [DW-1:0] m1_w_data,
   output logic          m1_gnt,
   output logic          m1_r_valid,
   output logic [DW-1:0] r_data,
   output logic [AW-1:0] ram_addr,
   output logic          ram_w_en,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data
);

   localparam int              BW   = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]   MAXB = BW'(MAX_BURST);

   arb_state_t    r_st;
   logic [BW-1:0] r_burst_cnt;
   logic          r_last;
   logic          r_rv0;
   logic          r_rv1;

   logic          w_pick_valid;
   logic          w_pick_idx;
   logic          w_win;
   logic          w_same_owner;

   arb_rr_pick #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_pick (
      .i_st        (r_st),
      .i_burst_cnt (r_burst_cnt),
      .i_last      (r_last),
      .i_req0      (m0_req),
      .i_req1      (m1_req),
      .o_valid     (w_pick_valid),
      .o_idx       (w_pick_idx)
   );

   // Grants are forced low while reset is asserted so nothing reaches the RAM.
   assign w_win  = w_pick_valid & rst_n;
   assign m0_gnt = w_win & ~w_pick_idx;
   assign m1_gnt = w_win &  w_pick_idx;

   assign w_same_owner = w_pick_idx ? (r_st == OWN1) : (r_st == OWN0);

   // Steer the winner onto the RAM; drive zeros when nobody is granted.
   always_comb begin
      ram_addr   = '0;
      ram_w_en   = 1'b0;
      ram_w_data = '0;
      if (m0_gnt) begin
         ram_addr   = m0_addr;
         ram_w_en   = m0_w_en;
         ram_w_data = m0_w_data;
      end else if (m1_gnt) begin
         ram_addr   = m1_addr;
         ram_w_en   = m1_w_en;
         ram_w_data = m1_w_data;
      end
   end

   // Ownership, saturating burst count and last-grant tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st        <= IDLE;
         r_burst_cnt <= '0;
         r_last      <= 1'b1;
      end else if (w_win) begin
         r_st   <= w_pick_idx ? OWN1 : OWN0;
         r_last <= w_pick_idx;
         if (!w_same_owner)
            r_burst_cnt <= BW'(1);
         else if (r_burst_cnt != MAXB)
            r_burst_cnt <= r_burst_cnt + BW'(1);
      end else begin
         r_st        <= IDLE;
         r_burst_cnt <= '0;
      end
   end

   // Read-return strobes: one cycle after an accepted read, dropped by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
      end else begin
         r_rv0 <= m0_gnt & ~m0_w_en;
         r_rv1 <= m1_gnt & ~m1_w_en;
      end
   end

   assign m0_r_valid = r_rv0;
   assign m1_r_valid = r_rv1;
   assign r_data     = ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural 256x16 RAM.
module tb_ram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_w_en, m0_gnt, m0_r_valid;
   logic [7:0]  m0_addr;
   logic [15:0] m0_w_data;
   logic        m1_req, m1_w_en, m1_gnt, m1_r_valid;
   logic [7:0]  m1_addr;
   logic [15:0] m1_w_data;
   logic [15:0] r_data;
   logic [7:0]  ram_addr;
   logic        ram_w_en;
   logic [15:0] ram_w_data;
   logic [15:0] ram_r_data;

   logic [15:0] mem [256];

   int errors = 0;
   int checks = 0;

   ram_arbiter #(.DW(16), .AW(8), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0_req     (m0_req),
      .m0_addr    (m0_addr),
      .m0_w_en    (m0_w_en),
      .m0_w_data  (m0_w_data),
      .m0_gnt     (m0_gnt),
      .m0_r_valid (m0_r_valid),
      .m1_req     (m1_req),
      .m1_addr    (m1_addr),
      .m1_w_en    (m1_w_en),
      .m1_w_data  (m1_w_data),
      .m1_gnt     (m1_gnt),
      .m1_r_valid (m1_r_valid),
      .r_data     (r_data),
      .ram_addr   (ram_addr),
      .ram_w_en   (ram_w_en),
      .ram_w_data (ram_w_data),
      .ram_r_data (ram_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM, read-before-write, 1-cycle read latency; preloaded while in reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[8'h01] <= 16'h0101;
         mem[8'h02] <= 16'h0202;
         mem[8'h03] <= 16'h0303;
         mem[8'h04] <= 16'h0404;
         mem[8'h05] <= 16'hBEEF;
         mem[8'h10] <= 16'h0000;
      end else if (ram_w_en) begin
         mem[ram_addr] <= ram_w_data;
      end
      ram_r_data <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b1; m0_addr = 8'h05; m0_w_en = 1'b1; m0_w_data = 16'hAAAA;
      m1_req = 1'b1; m1_addr = 8'h06; m1_w_en = 1'b1; m1_w_data = 16'h5555;
      #2;
      chk("rst_gnt0", 32'(m0_gnt), 0);
      chk("rst_gnt1", 32'(m1_gnt), 0);
      chk("rst_wen", 32'(ram_w_en), 0);
      tick(); tick();
      chk("rst_rv0", 32'(m0_r_valid), 0);
      chk("rst_rv1", 32'(m1_r_valid), 0);
      m0_req = 1'b0; m1_req = 1'b0; m0_w_en = 1'b0; m1_w_en = 1'b0;
      rst_n = 1'b1;

      // 1: lone m0 read of 0x05
      tick();
      m0_req = 1'b1; m0_addr = 8'h05;
      #1;
      chk("t1_gnt0", 32'(m0_gnt), 1);
      chk("t1_gnt1", 32'(m1_gnt), 0);
      chk("t1_addr", 32'(ram_addr), 32'h05);
      tick();
      m0_req = 1'b0;
      #1;
      chk("t1_rv0", 32'(m0_r_valid), 1);
      chk("t1_rv1", 32'(m1_r_valid), 0);
      chk("t1_data", 32'(r_data), 32'hBEEF);

      // 2: tie right after reset goes to m0, m1 follows without a bubble
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      m0_req = 1'b1; m0_addr = 8'h01;
      m1_req = 1'b1; m1_addr = 8'h02;
      #1;
      chk("t2_gnt0", 32'(m0_gnt), 1);
      chk("t2_gnt1", 32'(m1_gnt), 0);
      tick();
      m0_req = 1'b0;
      #1;
      chk("t2_gnt1b", 32'(m1_gnt), 1);
      chk("t2_rv0", 32'(m0_r_valid), 1);
      chk("t2_data0", 32'(r_data), 32'h0101);
      tick();
      m1_req = 1'b0;
      #1;
      chk("t2_rv1", 32'(m1_r_valid), 1);
      chk("t2_rv0b", 32'(m0_r_valid), 0);
      chk("t2_data1", 32'(r_data), 32'h0202);
      tick();

      // 3: both continuous -> 0,0,0,0,1,1,1,1,0,0,0,0
      m0_req = 1'b1; m0_addr = 8'h03;
      m1_req = 1'b1; m1_addr = 8'h04;
      for (int i = 0; i < 12; i++) begin
         automatic logic e = ((i / 4) % 2) == 1;
         automatic logic p = (((i - 1) / 4) % 2) == 1;
         #1;
         chk($sformatf("t3_gnt0_%0d", i), 32'(m0_gnt), 32'(!e));
         chk($sformatf("t3_gnt1_%0d", i), 32'(m1_gnt), 32'(e));
         if (i > 0) begin
            chk($sformatf("t3_rv0_%0d", i), 32'(m0_r_valid), 32'(!p));
            chk($sformatf("t3_rv1_%0d", i), 32'(m1_r_valid), 32'(p));
            chk($sformatf("t3_dat_%0d", i), 32'(r_data), p ? 32'h0404 : 32'h0303);
         end
         tick();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      #1;
      chk("t3_rv0_end", 32'(m0_r_valid), 1);
      chk("t3_rv1_end", 32'(m1_r_valid), 0);

      // 4: m1 writes 0x1234 @0x10, m0 reads it back
      m1_req = 1'b1; m1_addr = 8'h10; m1_w_en = 1'b1; m1_w_data = 16'h1234;
      #1;
      chk("t4_gnt1", 32'(m1_gnt), 1);
      chk("t4_wen", 32'(ram_w_en), 1);
      chk("t4_waddr", 32'(ram_addr), 32'h10);
      chk("t4_wdata", 32'(ram_w_data), 32'h1234);
      tick();
      m1_req = 1'b0; m1_w_en = 1'b0;
      m0_req = 1'b1; m0_addr = 8'h10;
      #1;
      chk("t4_wen_off", 32'(ram_w_en), 0);
      chk("t4_no_rv1", 32'(m1_r_valid), 0);
      chk("t4_gnt0", 32'(m0_gnt), 1);
      tick();
      m0_req = 1'b0;
      #1;
      chk("t4_rv0", 32'(m0_r_valid), 1);
      chk("t4_data", 32'(r_data), 32'h1234);
      chk("t4_rv1", 32'(m1_r_valid), 0);

      // 5: reset mid-burst with a read in flight
      m0_req = 1'b1; m0_addr = 8'h03;
      m1_req = 1'b1; m1_addr = 8'h04;
      tick(); tick();
      chk("t5_inflight", 32'(m0_r_valid | m1_r_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_gnt0", 32'(m0_gnt), 0);
      chk("t5_gnt1", 32'(m1_gnt), 0);
      chk("t5_rv0", 32'(m0_r_valid), 0);
      chk("t5_rv1", 32'(m1_r_valid), 0);
      chk("t5_wen", 32'(ram_w_en), 0);
      tick();
      chk("t5_rv_hold", 32'(m0_r_valid | m1_r_valid), 0);
      rst_n = 1'b1;
      #1;
      chk("t5_win0", 32'(m0_gnt), 1);
      chk("t5_win1", 32'(m1_gnt), 0);
      tick();
      m0_req = 1'b0; m1_req = 1'b0;
      #1;
      chk("t5_rv_post", 32'(m0_r_valid), 1);
      tick();

      // 6: lone m1, 10 back-to-back reads
      m1_req = 1'b1; m1_addr = 8'h02;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t6_gnt1_%0d", i), 32'(m1_gnt), 1);
         if (i > 0) chk($sformatf("t6_rv1_%0d", i), 32'(m1_r_valid), 1);
         tick();
      end
      chk("t6_burst", 32'(dut.r_burst_cnt), 4);
      m1_req = 1'b0;
      #1;
      chk("t6_rv1_end", 32'(m1_r_valid), 1);
      chk("t6_data", 32'(r_data), 32'h0202);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
